// File: rtl/cap_ctrl_if.sv
// Memory write port driven by the capture controller (master) into the sample RAM (slave).
interface cap_ctrl_if #(
  parameter int B = 8,
  parameter int N = 10
);
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [B-1:0] mem_di;

  modport master (output mem_we, mem_addr, mem_di);
  modport slave  (input  mem_we, mem_addr, mem_di);
endinterface

// File: rtl/cap_ctrl.sv
// Segmented capture controller: arms on START_REG, writes LEN_REG+1-sample segments on flag
// rising edges into a 2^N-deep memory. Define CAP_CTRL_TSTAMP_EN to add per-trigger timestamps.
module cap_ctrl #(
  parameter int B = 8,
  parameter int N = 10
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [B-1:0] din,
  input  logic         flag,
  input  logic         START_REG,
  input  logic [N-1:0] LEN_REG,
  cap_ctrl_if.master   mem,
  output logic         busy,
  output logic         done,
  output logic [N:0]   nseg
`ifdef CAP_CTRL_TSTAMP_EN
  ,
  output logic [31:0]  tstamp,
  output logic         tstamp_vld
`endif
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [N-1:0] A_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   S_ONE = {{N{1'b0}}, 1'b1};

  state_t       state, state_n;
  logic         start_r, start_q, flag_q;
  logic [N-1:0] len_r;
  logic [N-1:0] rem, rem_n;
  logic [N-1:0] acnt, acnt_n;
  logic         stop_q, stop_n;
  logic         we_q, we_n;
  logic [N-1:0] addr_q, addr_n;
  logic [B-1:0] di_q, di_n;
  logic [N:0]   nseg_n;
  logic         busy_n, done_n;

  logic start_rise, start_fall, trig, trig_acc, last;

  assign start_rise = start_r & ~start_q;
  assign start_fall = ~start_r & start_q;
  assign trig       = flag & ~flag_q;
  // stop wins over a coincident trigger
  assign trig_acc   = (state == ARMED) && !start_fall && trig;
  // the write currently on the bus closes the segment (length reached or memory full)
  assign last       = (rem == '0) || (addr_q == '1);

  assign mem.mem_we   = we_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_di   = di_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    addr_n  = addr_q;
    di_n    = di_q;
    rem_n   = rem;
    acnt_n  = acnt;
    stop_n  = stop_q;
    nseg_n  = nseg;
    case (state)
      IDLE, DONE: begin
        if (start_rise) begin
          state_n = ARMED;
          acnt_n  = '0;
          nseg_n  = '0;
          stop_n  = 1'b0;
        end
      end
      ARMED: begin
        if (start_fall) begin
          state_n = DONE;
        end else if (trig_acc) begin
          state_n = CAPTURE;
          we_n    = 1'b1;
          addr_n  = acnt;
          di_n    = din;
          rem_n   = len_r;
        end
      end
      CAPTURE: begin
        if (!last) begin
          we_n   = 1'b1;
          addr_n = addr_q + A_ONE;
          di_n   = din;
          rem_n  = rem - A_ONE;
          if (start_fall) stop_n = 1'b1;
        end else begin
          nseg_n  = nseg + S_ONE;
          acnt_n  = addr_q + A_ONE;
          state_n = ((addr_q == '1) || stop_q || start_fall) ? DONE : ARMED;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == ARMED) || (state_n == CAPTURE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      start_r <= 1'b0;
      start_q <= 1'b0;
      flag_q  <= 1'b0;
      len_r   <= '0;
      rem     <= '0;
      acnt    <= '0;
      stop_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      di_q    <= '0;
      nseg    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_r <= START_REG;
      start_q <= start_r;
      flag_q  <= flag;
      len_r   <= LEN_REG;
      rem     <= rem_n;
      acnt    <= acnt_n;
      stop_q  <= stop_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      di_q    <= di_n;
      nseg    <= nseg_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

`ifdef CAP_CTRL_TSTAMP_EN
  logic [31:0] tcnt;

  // timestamp lands together with the first write of the segment
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tcnt       <= '0;
      tstamp     <= '0;
      tstamp_vld <= 1'b0;
    end else begin
      tcnt       <= tcnt + 32'd1;
      tstamp_vld <= trig_acc;
      if (trig_acc) tstamp <= tcnt;
    end
  end
`endif

endmodule

// File: tb/tb_cap_ctrl.sv
// Randomized + directed bench for cap_ctrl (B=8, N=4) against a segment-level reference model.
module tb_cap_ctrl;
  localparam int B = 8, N = 4, DEPTH = 16;
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [B-1:0] din = '0;
  logic         flag = 1'b0;
  logic         START_REG = 1'b0;
  logic [N-1:0] LEN_REG = '0;
  logic         busy, done;
  logic [N:0]   nseg;
`ifdef CAP_CTRL_TSTAMP_EN
  logic [31:0]  tstamp;
  logic         tstamp_vld;
`endif

  cap_ctrl_if #(.B(B), .N(N)) mem ();

  cap_ctrl #(.B(B), .N(N)) dut (
    .aclk(aclk), .aresetn(aresetn), .din(din), .flag(flag),
    .START_REG(START_REG), .LEN_REG(LEN_REG), .mem(mem),
    .busy(busy), .done(done), .nseg(nseg)
`ifdef CAP_CTRL_TSTAMP_EN
    , .tstamp(tstamp), .tstamp_vld(tstamp_vld)
`endif
  );

  always #5 aclk = ~aclk;

  int total = 0, bad = 0;

  typedef struct { int a; int d; } wr_t;
  wr_t wlog[$];

  // reference model state: mode, where the next segment starts, current segment extent
  int m_mode = M_IDLE, m_next = 0, m_nseg = 0, m_cap_i = 0, m_seg_total = 0;
  bit m_stop = 0, s1 = 0, s2 = 0, f1 = 0;
  int l1 = 0;
  bit e_we = 0, e_tvld = 0;
  int e_addr = 0, e_di = 0;
  logic [31:0] m_tc = '0, e_ts = '0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // advance the model by one rising edge using the inputs present at that edge
  task automatic model_step();
    bit rise, fall, trig;
    e_we = 0;
    e_tvld = 0;
    if (!aresetn) begin
      m_mode = M_IDLE; m_nseg = 0; m_next = 0; m_stop = 0;
      e_addr = 0; e_di = 0; s1 = 0; s2 = 0; f1 = 0; l1 = 0;
      m_tc = '0; e_ts = '0;
      return;
    end
    rise = s1 & !s2;
    fall = !s1 & s2;
    trig = flag & !f1;
    case (m_mode)
      M_IDLE, M_DONE: if (rise) begin
        m_mode = M_ARMED; m_next = 0; m_nseg = 0; m_stop = 0;
      end
      M_ARMED: begin
        if (fall) m_mode = M_DONE;
        else if (trig) begin
          m_mode = M_CAP;
          m_cap_i = 0;
          m_seg_total = (l1 + 1 < DEPTH - m_next) ? l1 + 1 : DEPTH - m_next;
          e_we = 1; e_addr = m_next; e_di = din;
          e_ts = m_tc; e_tvld = 1;
        end
      end
      default: begin
        m_cap_i++;
        if (fall) m_stop = 1;
        if (m_cap_i < m_seg_total) begin
          e_we = 1; e_addr = m_next + m_cap_i; e_di = din;
        end else begin
          m_nseg++;
          m_next += m_seg_total;
          m_mode = (m_next == DEPTH || m_stop) ? M_DONE : M_ARMED;
        end
      end
    endcase
    s2 = s1; s1 = START_REG; f1 = flag; l1 = int'(LEN_REG);
    m_tc = m_tc + 32'd1;
  endtask

  task automatic step();
    @(posedge aclk);
    model_step();
    #1;
    check("mem_we",   mem.mem_we, e_we);
    check("mem_addr", mem.mem_addr, e_addr);
    check("mem_di",   mem.mem_di, e_di);
    check("busy",     busy, (m_mode == M_ARMED || m_mode == M_CAP));
    check("done",     done, (m_mode == M_DONE));
    check("nseg",     nseg, m_nseg);
`ifdef CAP_CTRL_TSTAMP_EN
    check("tstamp_vld", tstamp_vld, e_tvld);
    check("tstamp",     tstamp, e_ts);
`endif
    if (mem.mem_we) wlog.push_back('{int'(mem.mem_addr), int'(mem.mem_di)});
  endtask

  task automatic cycles(int n);
    repeat (n) step();
  endtask

  task automatic rearm();
    START_REG = 0; cycles(3);
    START_REG = 1; cycles(3);
  endtask

  initial begin
    bit found;
    aresetn = 0; cycles(2);
    check("rst_we", mem.mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_nseg", nseg, 0);
    aresetn = 1; cycles(1);

    // four-sample segment, data and addresses pinned literally
    LEN_REG = 3; START_REG = 1; cycles(3);
    check("arm_busy", busy, 1);
    wlog.delete();
    flag = 1; din = 8'h10; step();
    din = 8'h11; step();
    din = 8'h12; step();
    din = 8'h13; step();
    flag = 0; din = 8'h00; cycles(3);
    check("s1_count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      check("s1_addr", wlog[i].a, i);
      check("s1_data", wlog[i].d, 8'h10 + i);
    end
    check("s1_nseg", nseg, 1);
    check("s1_busy", busy, 1);
    check("s1_done", done, 0);

    // retrigger inside a segment is ignored
    LEN_REG = 7; rearm(); wlog.delete();
    flag = 1; din = 8'h20; step();
    flag = 0; cycles(2);
    flag = 1; step();
    flag = 0; cycles(10);
    check("s2_count", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) check("s2_addr", wlog[i].a, i);
    check("s2_nseg", nseg, 1);

    // fill to the top: third segment truncated, fourth trigger dropped
    LEN_REG = 5; rearm(); wlog.delete();
    for (int t = 0; t < 4; t++) begin
      flag = 1; din = 8'($urandom); step();
      flag = 0; cycles(9);
    end
    check("s3_count", wlog.size(), 16);
    if (wlog.size() == 16) begin
      check("s3_seg3_start", wlog[12].a, 12);
      check("s3_last_addr", wlog[15].a, 15);
    end
    check("s3_done", done, 1);
    check("s3_nseg", nseg, 3);
    check("s3_busy", busy, 0);

    // flag already high when arming
    LEN_REG = 1; START_REG = 0; flag = 1; cycles(3);
    START_REG = 1; cycles(5);
    wlog.delete(); cycles(3);
    check("s4_nowrite", wlog.size(), 0);
    check("s4_armed", busy, 1);
    flag = 0; step();
    flag = 1; din = 8'hA5; step();
    flag = 0; cycles(4);
    check("s4_count", wlog.size(), 2);
    if (wlog.size() > 0) begin
      check("s4_addr0", wlog[0].a, 0);
      check("s4_data0", wlog[0].d, 8'hA5);
    end

    // reset during the write to address 2
    LEN_REG = 7; rearm(); wlog.delete();
    flag = 1; din = 8'h33; step();
    flag = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem.mem_we && mem.mem_addr == 2) begin found = 1; break; end
      din = 8'($urandom); step();
    end
    check("s5_reached_addr2", found, 1);
    aresetn = 0; step();
    aresetn = 1;
    check("s5_we", mem.mem_we, 0);
    check("s5_addr", mem.mem_addr, 0);
    check("s5_busy", busy, 0);
    check("s5_nseg", nseg, 0);
    cycles(3);
    wlog.delete();
    flag = 1; din = 8'h44; step();
    flag = 0; cycles(10);
    check("s5_restart_count", wlog.size(), 8);
    if (wlog.size() > 0) check("s5_restart_addr", wlog[0].a, 0);

`ifdef CAP_CTRL_TSTAMP_EN
    // trigger exactly when the free-running counter reads 100
    aresetn = 0; step();
    aresetn = 1; LEN_REG = 2; START_REG = 1;
    for (int i = 0; i < 200 && m_tc != 32'd100; i++) step();
    flag = 1; step();
    check("ts_value", tstamp, 100);
    check("ts_vld", tstamp_vld, 1);
    check("ts_we", mem.mem_we, 1);
    check("ts_addr", mem.mem_addr, 0);
    flag = 0; cycles(5);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) START_REG = ~START_REG;
      if ($urandom_range(0, 2) == 0) flag = ~flag;
      if ($urandom_range(0, 19) == 0) LEN_REG = N'($urandom_range(0, 7));
      din = 8'($urandom);
      aresetn = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
